// File: rtl/buffer_arb_pkg.sv
// Shared defaults and FSM state encoding for the buffer bank arbiter.
package buffer_arb_pkg;

  localparam int DEF_N_REQ     = 4;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_MAX_BURST = 4;
  localparam int DEF_SRC_W     = $clog2(DEF_N_REQ);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_FLUSH = 2'd2
  } arb_state_e;

endpackage

// File: rtl/buffer_arbiter_rr_pick.sv
// Round-robin pick: first set request bit searching upward from last+1, wrapping.
module rr_pick #(
  parameter  int N_REQ = 4,
  localparam int SRC_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [SRC_W-1:0] last,
  output logic [SRC_W-1:0] winner,
  output logic             any
);

  logic [SRC_W-1:0] w_idx;

  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    winner = '0;
    any    = 1'b0;
    w_idx  = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      w_idx = SRC_W'((int'(last) + i) % N_REQ);
      if (!any && req[w_idx]) begin
        any    = 1'b1;
        winner = w_idx;
      end
    end
  end

endmodule

// File: rtl/buffer_arbiter.sv
// Round-robin burst arbiter for a buffer bank with registered output steering and global stall.
module buffer_arbiter
  import buffer_arb_pkg::*;
#(
  parameter  int N_REQ     = DEF_N_REQ,
  parameter  int DATA_W    = DEF_DATA_W,
  parameter  int MAX_BURST = DEF_MAX_BURST,
  localparam int SRC_W     = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        buf_full,
  input  logic [N_REQ-1:0]        buf_valid,
  input  logic [N_REQ*DATA_W-1:0] buf_data,
  input  logic                    downstream_ready,
  input  logic                    flush,
  output logic [N_REQ-1:0]        grant,
  output logic                    out_valid,
  output logic [DATA_W-1:0]       out_data,
  output logic [SRC_W-1:0]        out_src,
  output logic                    global_stall,
  output logic                    busy
);

  localparam int BURST_W = $clog2(MAX_BURST + 1);

  arb_state_e       r_state, w_state_nx;
  logic [N_REQ-1:0] r_grant, w_grant_nx;
  logic [SRC_W-1:0] r_own, w_own_nx;
  logic [SRC_W-1:0] r_last, w_last_nx;
  logic [BURST_W-1:0] r_burst, w_burst_nx;
  logic [SRC_W-1:0] r_src_d;
  logic             r_src_d_v;
  logic             r_stall;

  logic [SRC_W-1:0] w_idle_win, w_rot_win;
  logic             w_idle_any, w_rot_any;
  logic [N_REQ-1:0] w_rot_req;

  // The rotation pick excludes the current owner so a burst boundary only hands over to someone else.
  assign w_rot_req = req & ~(N_REQ'(1) << r_own);

  rr_pick #(.N_REQ(N_REQ)) u_pick_idle (
    .req    (req),
    .last   (r_last),
    .winner (w_idle_win),
    .any    (w_idle_any)
  );

  rr_pick #(.N_REQ(N_REQ)) u_pick_rot (
    .req    (w_rot_req),
    .last   (r_own),
    .winner (w_rot_win),
    .any    (w_rot_any)
  );

  always_comb begin
    w_state_nx = r_state;
    w_grant_nx = r_grant;
    w_own_nx   = r_own;
    w_last_nx  = r_last;
    w_burst_nx = r_burst;
    if (flush) begin
      w_state_nx = ST_FLUSH;
      w_grant_nx = '0;
      w_burst_nx = '0;
      w_last_nx  = SRC_W'(N_REQ - 1);
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_idle_any && downstream_ready) begin
            w_state_nx = ST_GRANT;
            w_grant_nx = N_REQ'(1) << w_idle_win;
            w_own_nx   = w_idle_win;
            w_burst_nx = BURST_W'(1);
          end
        end
        ST_GRANT: begin
          if (!downstream_ready || !req[r_own]) begin
            w_state_nx = ST_IDLE;
            w_grant_nx = '0;
            w_last_nx  = r_own;
            w_burst_nx = '0;
          end else if (r_burst == BURST_W'(MAX_BURST)) begin
            w_burst_nx = BURST_W'(1);
            if (w_rot_any) begin
              w_grant_nx = N_REQ'(1) << w_rot_win;
              w_own_nx   = w_rot_win;
              w_last_nx  = r_own;
            end
          end else begin
            w_burst_nx = r_burst + BURST_W'(1);
          end
        end
        ST_FLUSH: begin
          // Flush is low here; leaving through IDLE guarantees one grant-free cycle.
          w_state_nx = ST_IDLE;
          w_grant_nx = '0;
          w_burst_nx = '0;
          w_last_nx  = SRC_W'(N_REQ - 1);
        end
        default: w_state_nx = ST_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_grant   <= '0;
      r_own     <= '0;
      r_last    <= SRC_W'(N_REQ - 1);
      r_burst   <= '0;
      r_src_d   <= '0;
      r_src_d_v <= 1'b0;
      r_stall   <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_grant   <= w_grant_nx;
      r_own     <= w_own_nx;
      r_last    <= w_last_nx;
      r_burst   <= w_burst_nx;
      r_src_d   <= r_own;
      r_src_d_v <= |r_grant;
      r_stall   <= |buf_full;
    end
  end

  // Buffers register their word one edge after seeing grant, so steering follows the delayed index.
  assign grant        = r_grant;
  assign out_valid    = r_src_d_v & buf_valid[r_src_d];
  assign out_data     = r_src_d_v ? buf_data[r_src_d*DATA_W +: DATA_W] : '0;
  assign out_src      = r_src_d;
  assign global_stall = r_stall;
  assign busy         = (r_state != ST_IDLE);

endmodule

// File: doc/buffer_arbiter.md
# buffer_arbiter

Round-robin arbiter and output steering for a bank of `buffer_slots` instances that share one downstream pipeline port. It takes each buffer's `arbiter_req` and grants exactly one buffer per cycle. Each owner may hold the grant for a bounded burst. The arbiter steers the granted buffer's registered output to the shared port and aggregates the buffers' full flags into one global stall for stall management.

## Interface
Parameters:
- `N_REQ`, 4: number of buffers; 2..8.
- `DATA_W`, 32: data width.
- `MAX_BURST`, 4: maximum consecutive grant cycles per owner while others wait; ≥1.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `req` in N_REQ: per-buffer `arbiter_req`.
- `buf_full` in N_REQ: per-buffer `to_stall_mgmt`.
- `buf_valid` in N_REQ: per-buffer `out_valid`.
- `buf_data` in N_REQ*DATA_W: per-buffer `outputs`; buffer i occupies bits [i*DATA_W +: DATA_W].
- `downstream_ready` in 1: shared port can accept.
- `flush` in 1: pipeline flush, also driven to the buffers.
- `grant` out N_REQ: one-hot or zero, registered; drives each buffer's `arbiter_grant`.
- `out_valid` out 1: steered word valid.
- `out_data` out DATA_W: steered word.
- `out_src` out clog2(N_REQ): index of the buffer that produced `out_data`.
- `global_stall` out 1: registered OR of `buf_full`.
- `busy` out 1: FSM not in IDLE.

## Operation
- FSM states: IDLE, GRANT, FLUSH.
- IDLE:
  - If any `req` is set and `downstream_ready` is high, pick the winner (described below). Next cycle: `grant` = one-hot(winner), `burst_cnt` = 1, state = GRANT.
- GRANT, evaluated each cycle for the current owner `own`:
  - `flush`: go to FLUSH.
  - `downstream_ready` = 0 or `req[own]` = 0: release. `grant` = 0, `last` = own, state = IDLE.
  - `burst_cnt` == MAX_BURST and another request is pending: rotate. Grant the next winner, counted from own+1, directly with no idle cycle. `burst_cnt` = 1, `last` = own.
  - `burst_cnt` == MAX_BURST and no other request is pending: keep the grant and set `burst_cnt` = 1.
  - Otherwise: keep the grant and increment `burst_cnt`.
- Winner selection: the first set `req` bit searching upward from (`last`+1) mod N_REQ, with wrap-around. `last` resets to N_REQ-1, so buffer 0 wins first.
- FLUSH:
  - `grant` = 0, `burst_cnt` = 0, `last` = N_REQ-1.
  - Stays in FLUSH while `flush` is held. Goes to IDLE on the first cycle `flush` is low.
  - No grant is issued in the cycle after `flush` deasserts.
- `flush` takes priority over everything in every state.
- Steering:
  - A registered `src_d`/`src_d_v` captures the index and validity of `grant` each cycle.
  - `out_valid` = `src_d_v` & `buf_valid[src_d]`.
  - `out_data` = `buf_data[src_d]`, combinational mux.
  - `out_src` = `src_d`.
  - Non-granted `buf_valid` bits are ignored.
- `global_stall` <= |`buf_full`. It is independent of the FSM and is also updated during FLUSH.
- Invariant: `grant` is never multi-hot. A grant is never issued to a buffer whose `req` bit was low in the deciding cycle.

## Timing
- Reset values:
  - `grant` = 0, `out_valid` = 0, `out_data` = 0 (`src_d_v` = 0, so the steered output is zero).
  - `out_src` = 0, `global_stall` = 0, `busy` = 0.
  - State = IDLE, `last` = N_REQ-1, `burst_cnt` = 0.
- Reset asserted mid-burst returns all state to these values at the next edge.
- Request to grant: `req` sampled at edge k; `grant` high after edge k+1.
- Grant to data: a buffer sees `grant` in cycle t and registers its word at edge t+1. The word appears on `out_data` with `out_valid` in cycle t+1, one cycle after the grant.
- Ready drop: after `downstream_ready` falls, exactly one in-flight word can still arrive, in the following cycle. Downstream must absorb this one-word skid.
- Ownership switch at a burst boundary: the old owner's last word and the new owner's first word land in consecutive cycles with no bubble.
- `req` and `flush` in the same cycle: flush wins and no grant is issued.
- All `buf_full` set: `global_stall` = 1 one cycle later. Arbitration continues so the buffers can drain.

## Structure
- Package `buffer_arb_pkg`:
  - Default `N_REQ`, `DATA_W`, `MAX_BURST`.
  - Derived `SRC_W` = clog2(N_REQ).
  - State enum {IDLE, GRANT, FLUSH}.
- Sub-module `rr_pick`: combinational masked priority encoder. Inputs `req` and `last`; outputs `winner` and `any`. It is reused for the IDLE pick and the burst-rotation pick; the rotation pick masks out the current owner.

## Test plan
- Reset, then `req`=0001: `grant`=0001 after 1 cycle. The buffer's word 0xA5A5_0001 appears on `out_data` with `out_valid`=1 and `out_src`=0 one cycle later.
- `req`=1111 held, MAX_BURST=4, ready high: grant sequence 0001×4, 0010×4, 0100×4, 1000×4, 0001..., with no idle cycles between owners.
- Sole requester 0100 held for 10 cycles: `grant`=0100 continuously and `burst_cnt` wraps to 1 with no gap. After the release, `req`=0101 grants buffer 0 (searching from index 3).
- `downstream_ready` low mid-burst: `grant`=0 next cycle, exactly one more `out_valid` pulse, then silence. On ready high, arbitration resumes from `last`+1.
- `flush` for 2 cycles during a burst with `req`=1111: `grant`=0 throughout, `busy` stays high. In the first cycle after flush, `grant`=0 and state=IDLE; the next grant is 0001.
- `buf_full`=0010 for 1 cycle, then 0000: `global_stall` is a 1-cycle pulse, delayed by one cycle. Mid-burst `reset`: all outputs are at their reset values after the next edge.
